// File: rtl/byte_to_word_packer.sv
// Byte-to-word write packer: merges byte writes into one word write with per-lane enables.
// Optional idle auto-flush is built when PACKER_TIMEOUT_EN is defined.
module byte_to_word_packer #(
  parameter int BYTE_ADDR_WIDTH = 6,
  parameter int BYTES_PER_WORD  = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       byte_valid_in,
  output logic                                       byte_ready_out,
  input  logic [BYTE_ADDR_WIDTH-1:0]                 byte_addr_in,
  input  logic [7:0]                                 byte_data_in,
  input  logic                                       flush_in,
  output logic                                       word_valid_out,
  input  logic                                       word_ready_in,
  output logic [BYTE_ADDR_WIDTH-$clog2(BYTES_PER_WORD)-1:0] word_addr_out,
  output logic [BYTES_PER_WORD-1:0]                  word_byte_en_out,
  output logic [8*BYTES_PER_WORD-1:0]                word_data_out,
  output logic                                       busy_out
);
  localparam int LB = $clog2(BYTES_PER_WORD);
  localparam int WA = BYTE_ADDR_WIDTH - LB;
  localparam int W  = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {EMPTY = 2'd0, ACCUM = 2'd1, EMIT = 2'd2} state_t;

  function automatic logic [W-1:0] lane_word(input logic [LB-1:0] lane, input logic [7:0] d);
    lane_word = W'(d) << (8 * int'(lane));
  endfunction

  state_t                    state;
  logic [WA-1:0]             acc_addr;
  logic [BYTES_PER_WORD-1:0] acc_en;
  logic [W-1:0]              acc_data;

  logic [WA-1:0]             in_waddr;
  logic [LB-1:0]             in_lane;
  logic [BYTES_PER_WORD-1:0] in_en;
  logic [BYTES_PER_WORD-1:0] merged_en;
  logic                      conflict;
  logic                      accept;
  logic                      timeout_hit;

  assign in_waddr  = byte_addr_in[BYTE_ADDR_WIDTH-1:LB];
  assign in_lane   = byte_addr_in[LB-1:0];
  assign in_en     = BYTES_PER_WORD'(1) << in_lane;
  assign merged_en = acc_en | in_en;
  assign conflict  = (in_waddr != acc_addr) || ((acc_en & in_en) != '0);

  assign byte_ready_out = (state == EMPTY) || ((state == ACCUM) && !conflict);
  assign accept         = byte_valid_in && byte_ready_out;

`ifdef PACKER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt;

  // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state == ACCUM) && !accept && ((int'(idle_cnt) + 1) >= TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst || (state != ACCUM) || accept) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CW'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  // No idle counter in this build; the comparison is constant false.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      acc_addr <= '0;
      acc_en   <= '0;
      acc_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            acc_addr <= in_waddr;
            acc_en   <= in_en;
            acc_data <= lane_word(in_lane, byte_data_in);
            state    <= flush_in ? EMIT : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_en   <= merged_en;
            acc_data <= acc_data | lane_word(in_lane, byte_data_in);
          end
          // A stalled byte (valid but not ready) means a conflict: drain first.
          if ((accept && (&merged_en)) || (byte_valid_in && !byte_ready_out) ||
              flush_in || timeout_hit) begin
            state <= EMIT;
          end
        end
        EMIT: begin
          if (word_ready_in) begin
            acc_addr <= '0;
            acc_en   <= '0;
            acc_data <= '0;
            state    <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign word_valid_out   = (state == EMIT);
  assign busy_out         = (state != EMPTY);
  assign word_addr_out    = acc_addr;
  assign word_byte_en_out = acc_en;
  assign word_data_out    = acc_data;

endmodule
